ebu_arbiter: RTL and testbench
==============================

# ebu_arbiter

Two-requester AHB address-phase arbiter for the external bus unit. It shares one AHB manager port between the LSU bus FSM (requester 0, priority) and the IFU bus FSM (requester 1). Grant is locked for the whole length of a declared burst. A starvation counter bounds how long the IFU can be locked out. It also tracks which requester owns the data phase, so downstream logic can route HRDATA and HREADY.

## Interface
- BEATS_MAX, 4: maximum beats per burst; BEATW = $clog2(BEATS_MAX)+1.
- STARVE_LIMIT, 3: number of consecutive requester-0 wins while requester 1 is waiting before requester 1 is forced to win.
- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous assertion, active-low.
- Req0Trans  in  2  requester 0 HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- Req0Beats  in  BEATW  burst length of requester 0; sampled on an accepted NONSEQ.
- Req1Trans  in  2  requester 1 HTRANS.
- Req1Beats  in  BEATW  burst length of requester 1.
- HREADY  in  1  AHB ready.
- HTRANS  out  2  muxed HTRANS of the granted requester; IDLE when neither is granted.
- Grant0, Grant1  out  1  owns the address phase this cycle (one-hot or zero).
- Req0Wait, Req1Wait  out  1  requester must hold its address/control this cycle.
- Sel0, Sel1  out  1  owns the current data phase (registered).
- Locked  out  1  a burst is in progress (state OWN).

## Operation
- Registers:
  - State: IDLE or OWN.
  - Owner: 1 bit.
  - LastGrant: 1 bit.
  - BeatsLeft: BEATW bits.
  - StarveCnt: $clog2(STARVE_LIMIT+1) bits.
  - DataOwner: 1 bit.
  - DataValid: 1 bit.
- Reset values:
  - State = IDLE; Owner = LastGrant = DataOwner = 0.
  - BeatsLeft = 0, StarveCnt = 0, DataValid = 0.
  - Resulting outputs: Sel0 = Sel1 = 0, Locked = 0.
  - Grant/HTRANS/Wait follow from the inputs: with Req*Trans = IDLE, HTRANS = 00 and Grant* = 0.
- A request means ReqNTrans == NONSEQ.
- IDLE, HREADY=1 (arbitration):
  - If both requesters request, requester 0 wins unless StarveCnt == STARVE_LIMIT, in which case requester 1 wins.
  - If one requester requests, it wins.
  - Grant goes to the winner; HTRANS = winner's Trans.
- IDLE, HREADY=0:
  - Grant is held on LastGrant, and that requester's Trans is driven.
  - The other requester sees Wait=1.
- Beat count:
  - Effective beats = ReqNBeats, with 0 treated as 1 and values above BEATS_MAX clamped to BEATS_MAX.
  - An accepted NONSEQ (Grant & HREADY) with effective beats > 1 moves to OWN: Owner = winner, BeatsLeft = beats-1.
  - With effective beats = 1, the arbiter stays in IDLE.
- OWN:
  - Grant is locked to Owner and HTRANS = Owner's Trans.
  - On HREADY & (SEQ or NONSEQ): BeatsLeft decrements. If it reaches 0, return to IDLE on the next cycle.
  - BUSY holds the count.
  - Owner Trans = IDLE with HREADY=1 is an early termination: return to IDLE.
  - The non-owner sees Wait=1 whenever its Trans != IDLE.
- ReqNWait = (ReqNTrans != IDLE) & ~(GrantN & HREADY).
- LastGrant is updated to the current grant on every HREADY=1 cycle in which a grant is given.
- StarveCnt, on each accepted NONSEQ:
  - Requester-0 win while Req1Trans == NONSEQ: +1, saturating at STARVE_LIMIT.
  - Requester-1 win: cleared to 0.
  - Otherwise: unchanged.
- Data phase, on HREADY=1:
  - DataValid <= HTRANS[1]; DataOwner <= the granted requester.
  - SelN = DataValid & (DataOwner == N).
- Reset mid-burst: state returns to IDLE immediately (asynchronously). The outstanding data phase is dropped (DataValid=0).

## Timing
- Grant, HTRANS and Wait are combinational from Req*Trans, HREADY and the registers. There is zero-cycle latency from request to bus.
- The IDLE→OWN transition, counters and the data-phase owner update on the HCLK rising edge after the qualifying cycle.
- A single-beat transfer leaves the arbiter in IDLE, so back-to-back NONSEQs from alternating requesters are possible on consecutive cycles.
- When the last beat is accepted in OWN, the next cycle is IDLE and arbitrates with no bubble.

## Test plan
- Single requests:
  - Stimulus: Req0 NONSEQ, Beats=1, HREADY=1.
  - Required: Grant0=1, HTRANS=10 that cycle; Sel0=1 next cycle; Locked stays 0.
- Simultaneous requests and starvation:
  - Stimulus: Req0 and Req1 both hold single-beat NONSEQs every cycle.
  - Required: Grant order 0,0,0,1,0,0,0,1; StarveCnt sequence 1,2,3,0.
- Burst lock:
  - Stimulus: Req1 NONSEQ Beats=4, then SEQ×3 with a BUSY inserted; Req0 requests throughout.
  - Required: Locked=1 for 4 cycles including the BUSY; Req0Wait=1 throughout; Grant0 only after the 4th beat.
- HREADY low:
  - Stimulus: Req0 granted with HREADY=0 for 3 cycles; Req1 raises a request.
  - Required: Grant0 held, Req1Wait=1; Sel unchanged until HREADY=1.
- Early termination:
  - Stimulus: owner in OWN with BeatsLeft=2 drives IDLE with HREADY=1.
  - Required: State=IDLE next cycle; Req1 granted in that cycle.
- Reset mid-burst:
  - Stimulus: HRESETn low during OWN.
  - Required: Locked=0, Sel0=Sel1=0, StarveCnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/ebu_arbiter.sv
// Two-requester AHB address-phase arbiter: requester 0 has priority, bursts lock the grant,
// a starvation counter bounds requester 1's wait, and the data-phase owner is tracked for muxing.
module ebu_arbiter #(
  parameter int BEATS_MAX    = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int BEATW       = $clog2(BEATS_MAX) + 1,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [1:0]       Req0Trans,
  input  logic [BEATW-1:0] Req0Beats,
  input  logic [1:0]       Req1Trans,
  input  logic [BEATW-1:0] Req1Beats,
  input  logic             HREADY,
  output logic [1:0]       HTRANS,
  output logic             Grant0,
  output logic             Grant1,
  output logic             Req0Wait,
  output logic             Req1Wait,
  output logic             Sel0,
  output logic             Sel1,
  output logic             Locked
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [BEATW-1:0] beats_left_q, beats_left_d;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             data_owner_q, data_owner_d;
  logic             data_valid_q, data_valid_d;

  logic             req0, req1, accept, accept_ns;
  logic [BEATW-1:0] win_beats;

  // Zero-length bursts count as a single beat; oversize bursts clamp to the maximum.
  function automatic logic [BEATW-1:0] eff_beats(input logic [BEATW-1:0] b);
    if (b == '0) return BEATW'(1);
    else if (b > BEATW'(BEATS_MAX)) return BEATW'(BEATS_MAX);
    else return b;
  endfunction

  always_comb begin
    req0 = (Req0Trans == TR_NONSEQ);
    req1 = (Req1Trans == TR_NONSEQ);
    Grant0 = 1'b0;
    Grant1 = 1'b0;
    if (state_q == ST_OWN) begin
      Grant0 = ~owner_q;
      Grant1 = owner_q;
    end else if (HREADY) begin
      if (req0 && req1) begin
        Grant1 = (starve_cnt_q == SW'(STARVE_LIMIT));
        Grant0 = ~Grant1;
      end else begin
        Grant0 = req0;
        Grant1 = req1;
      end
    end else if (last_grant_q) begin
      Grant1 = (Req1Trans != TR_IDLE);
    end else begin
      Grant0 = (Req0Trans != TR_IDLE);
    end

    HTRANS    = Grant0 ? Req0Trans : (Grant1 ? Req1Trans : TR_IDLE);
    Req0Wait  = (Req0Trans != TR_IDLE) & ~(Grant0 & HREADY);
    Req1Wait  = (Req1Trans != TR_IDLE) & ~(Grant1 & HREADY);
    accept    = (Grant0 | Grant1) & HREADY;
    accept_ns = accept & (HTRANS == TR_NONSEQ);
    win_beats = eff_beats(Grant1 ? Req1Beats : Req0Beats);

    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beats_left_d = beats_left_q;
    starve_cnt_d = starve_cnt_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;

    if (state_q == ST_IDLE) begin
      if (accept_ns && win_beats > BEATW'(1)) begin
        state_d      = ST_OWN;
        owner_d      = Grant1;
        beats_left_d = win_beats - BEATW'(1);
      end
    end else if (HREADY) begin
      // BUSY holds the count; IDLE from the owner abandons the burst.
      if (HTRANS[1]) begin
        beats_left_d = beats_left_q - BEATW'(1);
        if (beats_left_q <= BEATW'(1)) state_d = ST_IDLE;
      end else if (HTRANS == TR_IDLE) begin
        beats_left_d = '0;
        state_d      = ST_IDLE;
      end
    end

    if (accept) last_grant_d = Grant1;

    if (accept_ns) begin
      if (Grant1) starve_cnt_d = '0;
      else if (req1 && starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SW'(1);
    end

    if (HREADY) begin
      data_valid_d = HTRANS[1];
      if (Grant0 | Grant1) data_owner_d = Grant1;
    end

    Sel0   = data_valid_q & ~data_owner_q;
    Sel1   = data_valid_q & data_owner_q;
    Locked = (state_q == ST_OWN);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      beats_left_q <= '0;
      starve_cnt_q <= '0;
      data_owner_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beats_left_q <= beats_left_d;
      starve_cnt_q <= starve_cnt_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_ebu_arbiter.sv
// Directed scenarios plus randomized traffic for ebu_arbiter, checked every cycle against
// a transaction-level model (remaining-beat count, last winner, starvation tally).
module tb_ebu_arbiter;

  logic       HCLK, HRESETn;
  logic [1:0] Req0Trans, Req1Trans, HTRANS;
  logic [2:0] Req0Beats, Req1Beats;
  logic       HREADY;
  logic       Grant0, Grant1, Req0Wait, Req1Wait, Sel0, Sel1, Locked;

  ebu_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .Req0Trans(Req0Trans), .Req0Beats(Req0Beats),
    .Req1Trans(Req1Trans), .Req1Beats(Req1Beats),
    .HREADY(HREADY), .HTRANS(HTRANS),
    .Grant0(Grant0), .Grant1(Grant1),
    .Req0Wait(Req0Wait), .Req1Wait(Req1Wait),
    .Sel0(Sel0), .Sel1(Sel1), .Locked(Locked)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: beats still owed by the locked owner (0 = not locked), etc.
  int m_left, m_owner, m_last, m_starve, m_dvalid, m_downer;
  int last_g;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_owner = 0; m_last = 0; m_starve = 0; m_dvalid = 0; m_downer = 0;
  endtask

  // Called at a negedge: drive, check combinational and registered outputs, then advance one cycle.
  task automatic cyc(input logic [1:0] t0, input logic [2:0] b0,
                     input logic [1:0] t1, input logic [2:0] b1, input logic hr);
    int tr[2];
    int bt[2];
    int g, eh, eff;
    bit acc_ns;
    Req0Trans = t0; Req0Beats = b0; Req1Trans = t1; Req1Beats = b1; HREADY = hr;
    tr[0] = t0; tr[1] = t1; bt[0] = b0; bt[1] = b1;
    #1;
    if (m_left > 0) g = m_owner;
    else if (hr) begin
      if (tr[0] == 2 && tr[1] == 2) g = (m_starve == 3) ? 1 : 0;
      else if (tr[0] == 2) g = 0;
      else if (tr[1] == 2) g = 1;
      else g = -1;
    end else g = (tr[m_last] != 0) ? m_last : -1;
    eh = (g < 0) ? 0 : tr[g];
    last_g = g;

    chk("grant0", Grant0, (g == 0));
    chk("grant1", Grant1, (g == 1));
    chk("htrans", HTRANS, eh);
    chk("wait0", Req0Wait, (tr[0] != 0) && !(g == 0 && hr));
    chk("wait1", Req1Wait, (tr[1] != 0) && !(g == 1 && hr));
    chk("sel0", Sel0, (m_dvalid == 1 && m_downer == 0));
    chk("sel1", Sel1, (m_dvalid == 1 && m_downer == 1));
    chk("locked", Locked, (m_left > 0));

    if (hr) begin
      acc_ns = (g >= 0) && (eh == 2);
      if (m_left == 0) begin
        if (acc_ns) begin
          eff = (bt[g] == 0) ? 1 : ((bt[g] > 4) ? 4 : bt[g]);
          if (eff > 1) begin m_left = eff - 1; m_owner = g; end
        end
      end else if (eh >= 2) m_left--;
      else if (eh == 0) m_left = 0;
      if (acc_ns) begin
        if (g == 1) m_starve = 0;
        else if (tr[1] == 2 && m_starve < 3) m_starve++;
      end
      if (g >= 0) begin m_last = g; m_downer = g; end
      m_dvalid = (eh >= 2);
    end
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;

  initial begin
    logic [7:0] order;
    int sseq[8];
    order = 8'b1000_1000;
    sseq = '{1, 2, 3, 0, 1, 2, 3, 0};

    HRESETn = 1'b0; Req0Trans = I; Req1Trans = I; Req0Beats = 3'd1; Req1Beats = 3'd1; HREADY = 1'b1;
    model_reset();
    #2;
    chk("rst_grant0", Grant0, 0);
    chk("rst_grant1", Grant1, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_sel", {Sel1, Sel0}, 0);
    chk("rst_locked", Locked, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Starvation: both requesters hold single-beat NONSEQs
    for (int i = 0; i < 8; i++) begin
      cyc(N, 3'd1, N, 3'd1, 1'b1);
      chk("starve_order", last_g, order[i]);
      chk("starve_cnt", dut.starve_cnt_q, sseq[i]);
    end

    // Single request, then Sel0 next cycle
    cyc(N, 3'd1, I, 3'd0, 1'b1);
    chk("single_grant0", last_g, 0);
    cyc(I, 3'd0, I, 3'd0, 1'b1);
    chk("single_locked", Locked, 0);

    // Burst lock: bring starvation to the limit so requester 1 wins a 4-beat burst
    for (int i = 0; i < 3; i++) cyc(N, 3'd1, N, 3'd1, 1'b1);
    cyc(N, 3'd1, N, 3'd4, 1'b1);
    chk("burst_win", last_g, 1);
    cyc(N, 3'd1, S, 3'd4, 1'b1);
    chk("burst_w0a", Req0Wait, 1);
    cyc(N, 3'd1, B, 3'd4, 1'b1);
    chk("burst_busy_lock", Locked, 1);
    cyc(N, 3'd1, S, 3'd4, 1'b1);
    cyc(N, 3'd1, S, 3'd4, 1'b1);
    chk("burst_last_g", last_g, 1);
    cyc(N, 3'd1, I, 3'd0, 1'b1);
    chk("burst_after", last_g, 0);

    // HREADY low: requester 0 held, requester 1 waits, Sel frozen
    cyc(N, 3'd1, I, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(N, 3'd1, N, 3'd1, 1'b0);
      chk("hrlow_g", last_g, 0);
    end
    cyc(I, 3'd0, N, 3'd1, 1'b1);

    // Early termination with two beats remaining
    cyc(N, 3'd3, I, 3'd0, 1'b1);
    cyc(I, 3'd3, N, 3'd1, 1'b1);
    chk("early_lock", last_g, 0);
    cyc(I, 3'd0, N, 3'd1, 1'b1);
    chk("early_g1", last_g, 1);

    // Reset in the middle of a burst
    cyc(N, 3'd4, N, 3'd1, 1'b1);
    cyc(S, 3'd4, N, 3'd1, 1'b1);
    HRESETn = 1'b0;
    #1;
    chk("mrst_locked", Locked, 0);
    chk("mrst_sel", {Sel1, Sel0}, 0);
    chk("mrst_starve", dut.starve_cnt_q, 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    Req0Trans = I; Req1Trans = I;
    @(negedge HCLK);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
